// File: rtl/cache_types_pkg.sv
// Types and default geometry shared by the cache line storage and its
// memory-side adaptor.
package cache_types_pkg;

  localparam int LINE_WIDTH  = 256;
  localparam int BURST_WIDTH = 64;
  localparam int BEATS       = LINE_WIDTH / BURST_WIDTH;

  typedef enum logic [2:0] {
    IDLE,
    FILL,
    FILL_DONE,
    WB,
    WB_DONE
  } adaptor_state_t;

endpackage

// File: rtl/cacheline_adaptor.sv
// Bridges a line-wide cache request to a beat-wide burst memory port (fill and writeback).
// Build option: CACHELINE_ADAPTOR_ALIGN_EN forces address_o to a line-aligned address.
module cacheline_adaptor #(
  parameter int LINE_WIDTH  = cache_types_pkg::LINE_WIDTH,
  parameter int BURST_WIDTH = cache_types_pkg::BURST_WIDTH,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [LINE_WIDTH-1:0]  line_i,
  output logic [LINE_WIDTH-1:0]  line_o,
  input  logic [ADDR_WIDTH-1:0]  address_i,
  input  logic                   read_i,
  input  logic                   write_i,
  output logic                   resp_o,
  input  logic [BURST_WIDTH-1:0] burst_i,
  output logic [BURST_WIDTH-1:0] burst_o,
  output logic [ADDR_WIDTH-1:0]  address_o,
  output logic                   read_o,
  output logic                   write_o,
  input  logic                   resp_i
);
  import cache_types_pkg::*;

  localparam int N_BEATS   = LINE_WIDTH / BURST_WIDTH;
  localparam int CNT_W     = (N_BEATS > 1) ? $clog2(N_BEATS) : 1;
  localparam int ALIGN_LSB = $clog2(LINE_WIDTH / 8);

`ifdef CACHELINE_ADAPTOR_ALIGN_EN
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}} << ALIGN_LSB;
`else
  localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = {ADDR_WIDTH{1'b1}};
`endif

  adaptor_state_t         r_state;
  adaptor_state_t         w_state_next;
  logic [CNT_W-1:0]       r_cnt;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [LINE_WIDTH-1:0]  r_wb_line;
  logic [LINE_WIDTH-1:0]  r_fill_line;
  logic [LINE_WIDTH-1:0]  r_line_out;
  logic [LINE_WIDTH-1:0]  w_fill_full;
  logic                   w_latch;
  logic                   w_beat;
  logic                   w_last;

  assign w_last    = (r_cnt == CNT_W'(N_BEATS - 1));
  assign line_o    = r_line_out;
  assign address_o = r_addr & ADDR_MASK;
  assign burst_o   = (r_state == WB) ? r_wb_line[r_cnt*BURST_WIDTH +: BURST_WIDTH]
                                     : '0;

  // Partially assembled line with the beat on burst_i dropped into its slot.
  always_comb begin
    w_fill_full = r_fill_line;
    w_fill_full[r_cnt*BURST_WIDTH +: BURST_WIDTH] = burst_i;
  end

  always_comb begin
    w_state_next = r_state;
    w_latch      = 1'b0;
    w_beat       = 1'b0;
    read_o       = 1'b0;
    write_o      = 1'b0;
    resp_o       = 1'b0;
    case (r_state)
      IDLE: begin
        if (write_i) begin
          w_latch      = 1'b1;
          w_state_next = WB;
        end else if (read_i) begin
          w_latch      = 1'b1;
          w_state_next = FILL;
        end
      end
      FILL: begin
        read_o = 1'b1;
        if (resp_i) begin
          w_beat = 1'b1;
          if (w_last) w_state_next = FILL_DONE;
        end
      end
      FILL_DONE: begin
        resp_o       = 1'b1;
        w_state_next = IDLE;
      end
      WB: begin
        write_o = 1'b1;
        if (resp_i) begin
          w_beat = 1'b1;
          if (w_last) w_state_next = WB_DONE;
        end
      end
      WB_DONE: begin
        resp_o       = 1'b1;
        w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= '0;
      r_addr      <= '0;
      r_wb_line   <= '0;
      r_fill_line <= '0;
      r_line_out  <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_latch) begin
        r_addr <= address_i;
        r_cnt  <= '0;
        if (write_i) r_wb_line <= line_i;
      end
      if (w_beat) begin
        r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        if (r_state == FILL) begin
          r_fill_line <= w_fill_full;
          // line_o only moves once the whole line has arrived
          if (w_last) r_line_out <= w_fill_full;
        end
      end
    end
  end

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Directed and randomized transactions for cacheline_adaptor against a line/beat reference model.
module tb_cacheline_adaptor;
  localparam int LW = 256;
  localparam int BW = 64;
  localparam int AW = 32;
  localparam int NB = LW / BW;

  logic          clk = 1'b0;
  logic          rst;
  logic [LW-1:0] line_i, line_o;
  logic [AW-1:0] address_i, address_o;
  logic          read_i, write_i, resp_o;
  logic [BW-1:0] burst_i, burst_o;
  logic          read_o, write_o, resp_i;

  int checks   = 0;
  int failures = 0;
  logic [LW-1:0] exp_line_o = '0;

  always #5 clk = ~clk;

  cacheline_adaptor dut (
    .clk(clk), .rst(rst),
    .line_i(line_i), .line_o(line_o),
    .address_i(address_i), .read_i(read_i), .write_i(write_i), .resp_o(resp_o),
    .burst_i(burst_i), .burst_o(burst_o), .address_o(address_o),
    .read_o(read_o), .write_o(write_o), .resp_i(resp_i)
  );

  task automatic check(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] a);
`ifdef CACHELINE_ADAPTOR_ALIGN_EN
    return a & ~32'h1f;
`else
    return a;
`endif
  endfunction

  function automatic logic [LW-1:0] rand_line();
    logic [LW-1:0] l;
    for (int i = 0; i < LW / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  function automatic int pick_gap(input int mode);
    if (mode == 0) return 0;
    if (mode == 1) return 1;
    return int'($urandom_range(0, 2));
  endfunction

  // Fill: memory delivers beat k = line[k*BW +: BW]; ends in the idle cycle after resp_o.
  task automatic fill_txn(input logic [AW-1:0] addr, input logic [LW-1:0] line,
                          input int gapmode, input bit drop_req);
    read_i = 1'b1; address_i = addr; resp_i = 1'b0;
    step();
    check("fill_start_read_o", LW'(read_o), LW'(1));
    check("fill_start_write_o", LW'(write_o), LW'(0));
    check("fill_address_o", LW'(address_o), LW'(exp_addr(addr)));
    if (drop_req) read_i = 1'b0;
    for (int k = 0; k < NB; k++) begin
      repeat (pick_gap(gapmode)) begin
        burst_i = {$urandom, $urandom};
        step();
        check("fill_gap_read_o", LW'(read_o), LW'(1));
        check("fill_gap_resp_o", LW'(resp_o), LW'(0));
        check("fill_gap_line_o_held", line_o, exp_line_o);
      end
      resp_i = 1'b1; burst_i = line[k*BW +: BW];
      step();
      resp_i = 1'b0; burst_i = {$urandom, $urandom};
      if (k < NB - 1) begin
        check("fill_beat_read_o", LW'(read_o), LW'(1));
        check("fill_beat_resp_o", LW'(resp_o), LW'(0));
        check("fill_beat_line_o_held", line_o, exp_line_o);
      end else begin
        exp_line_o = line;
        check("fill_done_read_o", LW'(read_o), LW'(0));
        check("fill_done_resp_o", LW'(resp_o), LW'(1));
        check("fill_done_line_o", line_o, exp_line_o);
        check("fill_done_address_o", LW'(address_o), LW'(exp_addr(addr)));
      end
    end
    read_i = 1'b0;
    step();
    check("fill_after_resp_o", LW'(resp_o), LW'(0));
    check("fill_after_read_o", LW'(read_o), LW'(0));
    check("fill_after_line_o", line_o, exp_line_o);
  endtask

  // Writeback: burst_o must present beat k until it is consumed.
  task automatic wb_txn(input logic [AW-1:0] addr, input logic [LW-1:0] line, input int gapmode);
    write_i = 1'b1; address_i = addr; line_i = line; resp_i = 1'b0;
    step();
    line_i = rand_line();
    check("wb_start_write_o", LW'(write_o), LW'(1));
    check("wb_start_read_o", LW'(read_o), LW'(0));
    check("wb_address_o", LW'(address_o), LW'(exp_addr(addr)));
    for (int k = 0; k < NB; k++) begin
      check("wb_burst_o", LW'(burst_o), LW'(line[k*BW +: BW]));
      repeat (pick_gap(gapmode)) begin
        step();
        check("wb_gap_burst_o_held", LW'(burst_o), LW'(line[k*BW +: BW]));
        check("wb_gap_write_o", LW'(write_o), LW'(1));
        check("wb_gap_resp_o", LW'(resp_o), LW'(0));
      end
      resp_i = 1'b1;
      step();
      resp_i = 1'b0;
      if (k < NB - 1) begin
        check("wb_beat_write_o", LW'(write_o), LW'(1));
        check("wb_beat_resp_o", LW'(resp_o), LW'(0));
      end else begin
        check("wb_done_write_o", LW'(write_o), LW'(0));
        check("wb_done_resp_o", LW'(resp_o), LW'(1));
        check("wb_done_read_o", LW'(read_o), LW'(0));
        check("wb_line_o_held", line_o, exp_line_o);
      end
    end
    write_i = 1'b0;
    step();
    check("wb_after_resp_o", LW'(resp_o), LW'(0));
    check("wb_after_write_o", LW'(write_o), LW'(0));
    check("wb_after_read_o", LW'(read_o), LW'(0));
  endtask

  task automatic idle_check(input int n);
    repeat (n) begin
      step();
      check("idle_read_o", LW'(read_o), LW'(0));
      check("idle_write_o", LW'(write_o), LW'(0));
      check("idle_resp_o", LW'(resp_o), LW'(0));
    end
  endtask

  initial begin
    logic [LW-1:0] l;
    rst = 1'b1; line_i = '0; address_i = '0; read_i = 1'b0; write_i = 1'b0;
    burst_i = '0; resp_i = 1'b0;
    step(); step();
    check("rst_resp_o", LW'(resp_o), LW'(0));
    check("rst_read_o", LW'(read_o), LW'(0));
    check("rst_write_o", LW'(write_o), LW'(0));
    check("rst_line_o", line_o, '0);
    check("rst_burst_o", LW'(burst_o), LW'(0));
    check("rst_address_o", LW'(address_o), LW'(0));
    rst = 1'b0;
    idle_check(1);

    // Directed fill at minimum latency
    l = {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
         64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111};
    fill_txn(32'h0000_1234, l, 0, 1'b0);

    // Directed writeback with resp_i every other cycle
    l = {64'hDDDD_DDDD_DDDD_DDDD, 64'hCCCC_CCCC_CCCC_CCCC,
         64'hBBBB_BBBB_BBBB_BBBB, 64'hAAAA_AAAA_AAAA_AAAA};
    wb_txn(32'h0000_ABC0, l, 1);

    // Both requests high: writeback first, then the held read starts a fill
    read_i = 1'b1;
    wb_txn(32'h0000_2040, rand_line(), 0);
    fill_txn(32'h0000_2040, rand_line(), 2, 1'b0);

    // resp_i in IDLE is ignored; read_i dropped mid-fill still completes
    resp_i = 1'b1; burst_i = {$urandom, $urandom};
    idle_check(3);
    resp_i = 1'b0;
    fill_txn(32'h0000_3008, rand_line(), 2, 1'b1);

    // Reset after two fill beats aborts and discards the partial line
    read_i = 1'b1; address_i = 32'h5555_0040;
    step();
    for (int k = 0; k < 2; k++) begin
      resp_i = 1'b1; burst_i = {$urandom, $urandom};
      step();
    end
    resp_i = 1'b0; rst = 1'b1; read_i = 1'b0;
    step();
    check("abort_read_o", LW'(read_o), LW'(0));
    check("abort_write_o", LW'(write_o), LW'(0));
    check("abort_resp_o", LW'(resp_o), LW'(0));
    check("abort_line_o", line_o, '0);
    check("abort_address_o", LW'(address_o), LW'(0));
    check("abort_burst_o", LW'(burst_o), LW'(0));
    rst = 1'b0;
    exp_line_o = '0;
    idle_check(1);
    fill_txn(32'h0000_4000, rand_line(), 0, 1'b0);

    // Randomized back-to-back mix
    for (int t = 0; t < 10; t++) begin
      if ($urandom_range(0, 1) == 1)
        wb_txn($urandom, rand_line(), 2);
      else
        fill_txn($urandom, rand_line(), 2, 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_check(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
